instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  IF stage that drives the IF/ID register read by the decode/hazard control unit, and obeys its
//  ID_stall, branch and jump redirect outputs. Owns the PC and the synchronous instruction-memory
//  port (1-cycle read latency), and holds a 1-entry skid buffer so stalls never lose or duplicate a word.
// PARAMETERS
//  RESET_PC    32'h0000_0000  byte address fetched first after reset
//  IMEM_AW     10             IMEM word-address width
//  DELAY_SLOT  1              1: keep the word after a taken branch/jump (MIPS delay slot); 0: squash it
// PORTS
//  Clk                 in   1        clock; all state updates on rising edge
//  Rst_n               in   1        asynchronous, active-low reset
//  ID_stall            in   1        decode stall; IF/ID holds, fetch freezes
//  ID_redirect         in   1        taken branch or jump (branch taken | force_branch) resolved in ID
//  ID_target           in   32       redirect byte address; bits [1:0] ignored
//  IMEM_En             out  1        read request this cycle
//  IMEM_Addr           out  IMEM_AW  word address = pc[IMEM_AW+1:2]
//  IMEM_Data           in   32       read data, valid the cycle after an IMEM_En=1 cycle
//  IF_ID_Instruction   out  32       instruction presented to decode
//  IF_ID_PCPlus4       out  32       its byte address + 4
//  IF_ID_Valid         out  1        IF/ID holds a real instruction (0 = bubble)
//  IF_PC               out  32       fetch PC (debug)
// BEHAVIOUR
//  Reset (async, Rst_n=0): fetch_pc=RESET_PC; IF_ID_Instruction=0 (NOP); IF_ID_PCPlus4=0;
//   IF_ID_Valid=0; IMEM_En=0; req_pending=0; skid_valid=0; state=BOOT. Reset mid-operation
//   drops any in-flight response and skid contents; fetch restarts from RESET_PC.
//  States: BOOT (first cycle after reset release) -> RUN; RUN <-> HOLD on ID_stall.
//  Incoming word W = skid_valid ? skid : (req_pending ? IMEM_Data : none); its PC rides with it.
//  RUN, ID_stall=0, ID_redirect=0: IMEM_En=1, addr=fetch_pc; fetch_pc<=fetch_pc+4;
//   req_pending<=1; IF/ID<=W (Valid=1), or Valid<=0 if no W.
//  RUN/HOLD, ID_stall=1: IMEM_En=0; fetch_pc, IF/ID held; ID_redirect ignored;
//   an arriving IMEM_Data goes to skid (skid_valid<=1); req_pending<=0; state=HOLD.
//   At most one request is ever outstanding, so skid depth 1 cannot overflow.
//  HOLD, ID_stall=0: treat as RUN; IF/ID<=skid if skid_valid; skid_valid<=0; state=RUN.
//  Redirect (ID_redirect=1 and ID_stall=0, any state but BOOT): IMEM_Addr=ID_target[IMEM_AW+1:2]
//   combinationally this cycle, IMEM_En=1; fetch_pc<=ID_target+4; skid_valid<=0.
//   DELAY_SLOT=1: IF/ID<=W (delay-slot instruction). DELAY_SLOT=0: IF_ID_Valid<=0, W discarded.
//   Target instruction enters IF/ID the next cycle (unless stalled then).
//  BOOT: IMEM_En=1, addr=RESET_PC; fetch_pc<=RESET_PC+4; IF_ID_Valid stays 0.
//  Latency: word at address A appears in IF/ID 2 cycles after A is issued with no stall.
//  Arithmetic: fetch_pc+4 and PCPlus4 wrap modulo 2^32; IMEM_Addr truncation wraps the IMEM.
//  ID_target low bits forced to 00. Throughput 1 instruction/cycle when unstalled.
// TESTING
//  1 Release reset, mem[i]=0x100+i, no stall -> IF_ID_Valid=1 from cycle 2; 0x100/PC+4=4, then 0x101/8, ...
//  2 Assert ID_stall 3 cycles while IF/ID holds PC 0x8 -> IF/ID frozen, IMEM_En=0 during stall;
//    after release 0xC, 0x10 follow back-to-back with no gap, loss or duplicate.
//  3 DELAY_SLOT=1, branch at 0x10 redirects to 0x40 -> IF/ID sequence 0x10, 0x14, 0x40, 0x44.
//  4 DELAY_SLOT=0, same stimulus -> 0x10, bubble (Valid=0), 0x40, 0x44.
//  5 ID_redirect=1 with ID_stall=1 -> ignored. Redirect in stall-release cycle with skid full
//    -> skid word (delay slot) loaded, then target; skid cleared.
//  6 Drop Rst_n mid-stream between edges -> outputs reset immediately; on release refetch from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the fetch PC, drives a 1-cycle-latency instruction memory and loads the IF/ID register.
// A 1-entry skid buffer catches the word that lands while decode is stalled.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_AW    = 10,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               ID_stall,
  input  logic               ID_redirect,
  input  logic [31:0]        ID_target,
  output logic               IMEM_En,
  output logic [IMEM_AW-1:0] IMEM_Addr,
  input  logic [31:0]        IMEM_Data,
  output logic [31:0]        IF_ID_Instruction,
  output logic [31:0]        IF_ID_PCPlus4,
  output logic               IF_ID_Valid,
  output logic [31:0]        IF_PC
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        req_pending;
  logic [31:0] req_pc;
  logic        skid_valid;
  logic [31:0] skid;
  logic [31:0] skid_pc;

  logic [31:0] target_al;
  logic        do_redirect;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        load_w;

  assign target_al   = ID_target & 32'hFFFF_FFFC;
  assign do_redirect = (state != BOOT) && ID_redirect && !ID_stall;

  // Incoming word: skid has priority over the live memory response.
  assign w_valid = skid_valid || req_pending;
  assign w_instr = skid_valid ? skid : IMEM_Data;
  assign w_pc    = skid_valid ? skid_pc : req_pc;
  assign load_w  = w_valid && (DELAY_SLOT || !do_redirect);

  // Memory request is combinational so a redirect target is fetched in the resolving cycle.
  always_comb begin
    IMEM_En   = 1'b0;
    IMEM_Addr = fetch_pc[IMEM_AW+1:2];
    if (Rst_n && (state == BOOT || !ID_stall)) begin
      IMEM_En = 1'b1;
    end
    if (do_redirect) begin
      IMEM_Addr = target_al[IMEM_AW+1:2];
    end
  end

  assign IF_PC = fetch_pc;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state             <= BOOT;
      fetch_pc          <= RESET_PC;
      req_pending       <= 1'b0;
      req_pc            <= RESET_PC;
      skid_valid        <= 1'b0;
      skid              <= 32'd0;
      skid_pc           <= 32'd0;
      IF_ID_Instruction <= 32'd0;
      IF_ID_PCPlus4     <= 32'd0;
      IF_ID_Valid       <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          req_pc      <= fetch_pc;
          fetch_pc    <= fetch_pc + 32'd4;
          req_pending <= 1'b1;
          state       <= RUN;
        end
        default: begin
          if (ID_stall) begin
            if (req_pending) begin
              skid       <= IMEM_Data;
              skid_pc    <= req_pc;
              skid_valid <= 1'b1;
            end
            req_pending <= 1'b0;
            state       <= HOLD;
          end else begin
            state       <= RUN;
            skid_valid  <= 1'b0;
            req_pending <= 1'b1;
            if (do_redirect) begin
              req_pc   <= target_al;
              fetch_pc <= target_al + 32'd4;
            end else begin
              req_pc   <= fetch_pc;
              fetch_pc <= fetch_pc + 32'd4;
            end
            IF_ID_Valid <= load_w;
            if (load_w) begin
              IF_ID_Instruction <= w_instr;
              IF_ID_PCPlus4     <= w_pc + 32'd4;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: two fetch units (delay slot on/off) share stimulus; a scoreboard per unit
// holds the expected IF/ID contents for every unstalled clock edge.
module tb_instruction_fetch_unit;

  localparam int unsigned AW = 10;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] p4;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          id_stall;
  logic          id_redirect;
  logic [31:0]   id_target;

  logic          en1, en0;
  logic [AW-1:0] addr1, addr0;
  logic [31:0]   data1, data0;
  logic [31:0]   ins1, ins0, p41, p40, pc1, pc0;
  logic          v1, v0;

  logic [31:0]   mem [1024];
  exp_t          q1[$];
  exp_t          q0[$];
  int            ncmp;
  int            nerr;
  logic          mon_ld;

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW), .DELAY_SLOT(1'b1)) dut_ds1 (
    .Clk(clk), .Rst_n(rst_n), .ID_stall(id_stall), .ID_redirect(id_redirect),
    .ID_target(id_target), .IMEM_En(en1), .IMEM_Addr(addr1), .IMEM_Data(data1),
    .IF_ID_Instruction(ins1), .IF_ID_PCPlus4(p41), .IF_ID_Valid(v1), .IF_PC(pc1)
  );

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW), .DELAY_SLOT(1'b0)) dut_ds0 (
    .Clk(clk), .Rst_n(rst_n), .ID_stall(id_stall), .ID_redirect(id_redirect),
    .ID_target(id_target), .IMEM_En(en0), .IMEM_Addr(addr0), .IMEM_Data(data0),
    .IF_ID_Instruction(ins0), .IF_ID_PCPlus4(p40), .IF_ID_Valid(v0), .IF_PC(pc0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (en1) data1 <= mem[addr1];
  always @(posedge clk) if (en0) data0 <= mem[addr0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_cmp(input string tag, input int depth, input exp_t e,
                        input logic v, input logic [31:0] ins, input logic [31:0] p4);
    ncmp++;
    assert (depth > 0) else begin
      nerr++;
      $error("FAIL %s_underflow: observed depth %0d expected >0", tag, depth);
    end
    if (depth > 0) begin
      chk({tag, "_valid"}, 32'(v), 32'(e.v));
      if (e.v) begin
        chk({tag, "_instr"}, ins, e.ins);
        chk({tag, "_pcplus4"}, p4, e.p4);
      end
    end
  endtask

  task automatic push2(input logic v, input logic [31:0] ins, input logic [31:0] p4);
    q1.push_back('{v: v, ins: ins, p4: p4});
    q0.push_back('{v: v, ins: ins, p4: p4});
  endtask

  task automatic push_split(input logic [31:0] ins, input logic [31:0] p4);
    q1.push_back('{v: 1'b1, ins: ins, p4: p4});
    q0.push_back('{v: 1'b0, ins: 32'd0, p4: 32'd0});
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] t);
    @(negedge clk);
    id_stall    = s;
    id_redirect = r;
    id_target   = t;
  endtask

  // Every edge taken out of reset with decode unstalled loads IF/ID (word or bubble).
  always @(posedge clk) begin
    exp_t e1, e0;
    int   d1, d0;
    mon_ld = rst_n && !id_stall;
    #1;
    if (mon_ld) begin
      d1 = q1.size();
      d0 = q0.size();
      e1 = '{v: 1'b0, ins: 32'd0, p4: 32'd0};
      e0 = '{v: 1'b0, ins: 32'd0, p4: 32'd0};
      if (d1 > 0) e1 = q1.pop_front();
      if (d0 > 0) e0 = q0.pop_front();
      sb_cmp("ds1", d1, e1, v1, ins1, p41);
      sb_cmp("ds0", d0, e0, v0, ins0, p40);
    end
  end

  initial begin
    ncmp = 0;
    nerr = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 32'(i);
    rst_n       = 1'b0;
    id_stall    = 1'b0;
    id_redirect = 1'b0;
    id_target   = 32'd0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(v1), 32'd0);
    chk("rst_instr", ins1, 32'd0);
    chk("rst_pcplus4", p41, 32'd0);
    chk("rst_imem_en", 32'(en1), 32'd0);
    chk("rst_if_pc", pc1, 32'd0);

    // Straight-line fetch from reset.
    push2(1'b0, 32'd0, 32'd0);
    push2(1'b1, 32'h100, 32'h4);
    push2(1'b1, 32'h101, 32'h8);
    push2(1'b1, 32'h102, 32'hC);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_imem_en", 32'(en1), 32'd1);
    chk("boot_imem_addr", 32'(addr1), 32'd0);
    repeat (3) drive(1'b0, 1'b0, 32'd0);

    // Three-cycle stall while IF/ID holds PC 0x8.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      #1;
      chk("stall_imem_en", 32'(en1), 32'd0);
      chk("stall_hold_instr", ins1, 32'h102);
      chk("stall_hold_pcplus4", p41, 32'hC);
      chk("stall_hold_valid", 32'(v1), 32'd1);
    end
    push2(1'b1, 32'h103, 32'h10);
    push2(1'b1, 32'h104, 32'h14);
    repeat (2) drive(1'b0, 1'b0, 32'd0);

    // Branch at 0x10 to 0x40.
    push_split(32'h105, 32'h18);
    push2(1'b1, 32'h110, 32'h44);
    push2(1'b1, 32'h111, 32'h48);
    drive(1'b0, 1'b1, 32'h0000_0043);
    #1;
    chk("redir_imem_en", 32'(en1), 32'd1);
    chk("redir_imem_addr", 32'(addr1), 32'h10);
    chk("redir_imem_addr_ds0", 32'(addr0), 32'h10);
    drive(1'b0, 1'b0, 32'd0);
    #1;
    chk("redir_if_pc", pc1, 32'h44);
    drive(1'b0, 1'b0, 32'd0);

    // Redirect under stall is ignored; redirect on release drains the skid first.
    drive(1'b1, 1'b1, 32'h200);
    #1;
    chk("stall_redir_imem_en", 32'(en1), 32'd0);
    push_split(32'h112, 32'h4C);
    push2(1'b1, 32'h120, 32'h84);
    push2(1'b1, 32'h121, 32'h88);
    drive(1'b0, 1'b1, 32'h80);
    #1;
    chk("skid_redir_imem_addr", 32'(addr1), 32'h20);
    chk("skid_redir_held_pc", pc1, 32'h4C);
    drive(1'b0, 1'b0, 32'd0);
    #1;
    chk("skid_redir_if_pc", pc1, 32'h84);
    drive(1'b0, 1'b0, 32'd0);

    // Asynchronous reset between edges, then refetch from the reset PC.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(v1), 32'd0);
    chk("midrst_instr", ins1, 32'd0);
    chk("midrst_imem_en", 32'(en1), 32'd0);
    chk("midrst_if_pc", pc1, 32'd0);
    chk("midrst_valid_ds0", 32'(v0), 32'd0);
    push2(1'b0, 32'd0, 32'd0);
    push2(1'b1, 32'h100, 32'h4);
    push2(1'b1, 32'h101, 32'h8);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("ds1_leftover", 32'(q1.size()), 32'd0);
    chk("ds0_leftover", 32'(q0.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
